// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment reader: active-low segment
// patterns (bit0=a .. bit6=g), the error code, the FSM states and the result payload.
package seven_seg_pkg;

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned RUN_W  = 8;

    // Same encoding as seven_segment_display (active-low, g..a)
    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    localparam logic [CODE_W-1:0] ERR_CODE = 4'hF;

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } state_e;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              err;
    } result_t;

endpackage

// File: rtl/seven_segment_pattern_decoder.sv
// Combinational lookup from an active-low segment pattern to {code, err};
// blank_c flags the all-off pattern, which carries no result.
module seven_segment_pattern_decoder
    import seven_seg_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output result_t          result_c,
    output logic             blank_c
);

    always_comb begin
        result_c.code = ERR_CODE;
        result_c.err  = 1'b1;
        blank_c       = 1'b0;
        case (pattern)
            SEG_0:     begin result_c.code = CODE_W'(0); result_c.err = 1'b0; end
            SEG_1:     begin result_c.code = CODE_W'(1); result_c.err = 1'b0; end
            SEG_2:     begin result_c.code = CODE_W'(2); result_c.err = 1'b0; end
            SEG_3:     begin result_c.code = CODE_W'(3); result_c.err = 1'b0; end
            SEG_4:     begin result_c.code = CODE_W'(4); result_c.err = 1'b0; end
            SEG_5:     begin result_c.code = CODE_W'(5); result_c.err = 1'b0; end
            SEG_6:     begin result_c.code = CODE_W'(6); result_c.err = 1'b0; end
            SEG_7:     begin result_c.code = CODE_W'(7); result_c.err = 1'b0; end
            SEG_8:     begin result_c.code = CODE_W'(8); result_c.err = 1'b0; end
            SEG_9:     begin result_c.code = CODE_W'(9); result_c.err = 1'b0; end
            SEG_BLANK: blank_c = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: rtl/seven_segment_reader.sv
// Debounces an asynchronous seven-segment pattern, decodes it once it has been
// stable for STABLE_CYCLES samples, and offers the result on a valid/ready port.
module seven_segment_reader
    import seven_seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SEG_W-1:0]  HEX,
    output logic [CODE_W-1:0] code,
    output logic              err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow
);

    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = '1;

    logic [SEG_W-1:0]  s_q;
    logic [RUN_W-1:0]  run;
    state_e            state;
    state_e            state_nx;

    logic [RUN_W-1:0]  run_nx;
    logic [CODE_W-1:0] code_nx;
    logic              err_nx;
    logic              valid_nx;
    logic              overflow_nx;

    result_t           dec_c;
    logic              blank_c;
    logic              changed_c;
    logic              emit_c;
    logic              xfer_c;

    // Decode the registered sample; it equals HEX whenever an emission fires
    seven_segment_pattern_decoder u_decoder (
        .pattern  (s_q),
        .result_c (dec_c),
        .blank_c  (blank_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOCKED;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        emit_c      = 1'b0;
        run_nx      = run;
        code_nx     = code;
        err_nx      = err;
        valid_nx    = out_valid;
        overflow_nx = overflow;

        changed_c = (HEX != s_q);
        xfer_c    = out_valid && out_ready;

        // Stability count restarts on any change, including one-cycle glitches
        if (changed_c) begin
            run_nx = RUN_W'(1);
        end else if (run != RUN_MAX) begin
            run_nx = run + RUN_W'(1);
        end

        case (state)
            SETTLE: begin
                if (!changed_c && run == RUN_LAST) begin
                    emit_c   = 1'b1;
                    state_nx = LOCKED;
                end
            end
            LOCKED: begin
                if (changed_c) begin
                    state_nx = SETTLE;
                end
            end
            default: state_nx = LOCKED;
        endcase

        // Blank emissions only re-lock; a full holding register drops the new result
        if (emit_c && !blank_c) begin
            if (!out_valid || out_ready) begin
                code_nx  = dec_c.code;
                err_nx   = dec_c.err;
                valid_nx = 1'b1;
            end else begin
                overflow_nx = 1'b1;
            end
        end else if (xfer_c) begin
            valid_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q       <= SEG_BLANK;
            run       <= '0;
            code      <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            s_q       <= HEX;
            run       <= run_nx;
            code      <= code_nx;
            err       <= err_nx;
            out_valid <= valid_nx;
            overflow  <= overflow_nx;
        end
    end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Self-checking bench for seven_segment_reader: constant vector table, directed
// corner sequences and randomized traffic against a sample-history reference model.
module tb_seven_segment_reader;

    localparam int STI = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] HEX;
    logic [3:0] code;
    logic       err;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: last STI+1 samples plus the holding register
    logic [6:0] hist[$];
    logic       mv;
    logic [3:0] mcode;
    logic       merr;
    logic       movf;
    logic [6:0] pats [10];

    typedef struct {
        logic [6:0] hex;
        logic       rdy;
        logic       ev;
        logic [3:0] ec;
        logic       ee;
        logic       eo;
    } vec_t;

    vec_t tbl [20];

    seven_segment_reader #(.STABLE_CYCLES(STI)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .HEX       (HEX),
        .code      (code),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        hist.delete();
        hist.push_back(7'h7F);
        mv    = 1'b0;
        mcode = 4'd0;
        merr  = 1'b0;
        movf  = 1'b0;
    endtask

    // A pattern yields a result on the edge where it has been seen exactly STI times in a row
    task automatic model_edge(input logic [6:0] h, input logic r);
        logic       emit;
        logic [3:0] c;
        logic       e;
        int         n;
        hist.push_back(h);
        if (hist.size() > STI + 1) void'(hist.pop_front());
        n    = hist.size();
        emit = 1'b0;
        if (n == STI + 1 && h != 7'h7F) begin
            emit = 1'b1;
            for (int i = 1; i <= STI; i++) if (hist[n-i] != h) emit = 1'b0;
            if (hist[0] == h) emit = 1'b0;
        end
        c = 4'hF;
        e = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (pats[i] == h) begin
                c = 4'(i);
                e = 1'b0;
            end
        end
        if (emit) begin
            if (!mv || r) begin
                mv    = 1'b1;
                mcode = c;
                merr  = e;
            end else begin
                movf = 1'b1;
            end
        end else if (mv && r) begin
            mv = 1'b0;
        end
    endtask

    task automatic step(input logic [6:0] h, input logic r);
        HEX       = h;
        out_ready = r;
        @(posedge clk);
        model_edge(h, r);
        #1;
        check("valid", out_valid, mv);
        check("overflow", overflow, movf);
        if (mv) begin
            check("code", code, mcode);
            check("err", err, merr);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_code", code, 0);
        check("rst_err", err, 0);
        check("rst_valid", out_valid, 0);
        check("rst_overflow", overflow, 0);
        @(posedge clk);
        #1;
        check("rst_valid_held", out_valid, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int first;
        int cnt;
        logic [6:0] h;
        int len;
        int sel;

        pats = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        for (int i = 0; i < 20; i++) begin
            tbl[i].hex = (i < 8) ? 7'h10 : ((i < 13) ? 7'h55 : 7'h7F);
            tbl[i].rdy = 1'b1;
            tbl[i].ev  = (i == 3 || i == 11);
            tbl[i].ec  = (i == 3) ? 4'd9 : ((i == 11) ? 4'hF : 4'd0);
            tbl[i].ee  = (i == 11);
            tbl[i].eo  = 1'b0;
        end

        rst_n     = 1'b0;
        HEX       = 7'h7F;
        out_ready = 1'b0;
        model_reset();
        #3;
        do_reset();

        // Digit 9 held, illegal 55, then blank
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].hex, tbl[i].rdy);
            check("tbl_valid", out_valid, tbl[i].ev);
            check("tbl_overflow", overflow, tbl[i].eo);
            if (tbl[i].ev) begin
                check("tbl_code", code, tbl[i].ec);
                check("tbl_err", err, tbl[i].ee);
            end
        end

        // One-cycle glitch restarts the count
        do_reset();
        first = -1;
        cnt   = 0;
        for (int k = 1; k <= 16; k++) begin
            step((k == 2) ? 7'h79 : 7'h78, 1'b1);
            if (out_valid) begin
                cnt++;
                if (first < 0) first = k;
                check("glitch_code", code, 7);
            end
        end
        check("glitch_first_edge", first, 6);
        check("glitch_count", cnt, 1);

        // Holding register full: second result dropped, overflow sticks
        do_reset();
        for (int k = 0; k < 6; k++) step(7'h40, 1'b0);
        check("ovf_hold_valid", out_valid, 1);
        check("ovf_hold_code", code, 0);
        check("ovf_before", overflow, 0);
        for (int k = 0; k < 6; k++) step(7'h79, 1'b0);
        check("ovf_held_valid", out_valid, 1);
        check("ovf_held_code", code, 0);
        check("ovf_set", overflow, 1);
        step(7'h79, 1'b1);
        check("ovf_xfer_clears", out_valid, 0);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step(7'h79, 1'b1);
            if (out_valid) cnt++;
        end
        check("ovf_no_code1", cnt, 0);
        check("ovf_sticky", overflow, 1);

        // Transfer and emission on the same edge
        do_reset();
        for (int k = 0; k < 4; k++) step(7'h40, 1'b0);
        check("same_first_code", code, 0);
        for (int k = 0; k < 3; k++) step(7'h79, 1'b0);
        step(7'h79, 1'b1);
        check("same_valid", out_valid, 1);
        check("same_code", code, 1);
        check("same_overflow", overflow, 0);
        step(7'h79, 1'b0);
        check("same_hold_code", code, 1);

        // Reset mid-settle with a result pending
        do_reset();
        for (int k = 0; k < 4; k++) step(7'h40, 1'b0);
        step(7'h79, 1'b0);
        step(7'h79, 1'b0);
        check("midrst_pending", out_valid, 1);
        do_reset();
        first = -1;
        for (int k = 1; k <= 6; k++) begin
            step(7'h79, 1'b0);
            if (out_valid && first < 0) first = k;
        end
        check("midrst_resettle_edge", first, STI);
        check("midrst_code", code, 1);

        // Randomized traffic against the model
        do_reset();
        for (int s = 0; s < 400; s++) begin
            sel = int'($urandom_range(0, 11));
            if (sel < 10) h = pats[sel];
            else if (sel == 10) h = 7'h7F;
            else h = 7'($urandom);
            len = int'($urandom_range(1, 8));
            for (int k = 0; k < len; k++) step(h, $urandom_range(0, 9) < 7);
            if ($urandom_range(0, 39) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
